// File: rtl/stream_harness.sv
// Stimulus/response harness for stb/ack arithmetic blocks: per-channel operand generators,
// a throttled result sink with rotate-xor checksum, and a stall timeout.

module stream_harness_chan #(
    parameter int WIDTH = 16,
    parameter int COUNT = 256,
    parameter int IDX   = 0,
    parameter int SEED  = 16'h0001,
    parameter int POLY  = 16'hB400
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] cfg_value,
    input  logic             ack,
    output logic [WIDTH-1:0] z,
    output logic             stb
);
    localparam int CW = $clog2(COUNT + 1);
    localparam logic [WIDTH-1:0] SEED_RAW = WIDTH'(SEED + IDX);
    localparam logic [WIDTH-1:0] SEED_I   = (SEED_RAW == '0) ? WIDTH'(1) : SEED_RAW;
    localparam logic [WIDTH-1:0] POLY_W   = WIDTH'(POLY);

    logic [1:0]       mode_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] word0, nxt;

    always_comb begin
        case (mode)
            2'd1:    word0 = SEED_I;
            2'd2:    word0 = cfg_value;
            default: word0 = WIDTH'(IDX);
        endcase
    end

    // Constant mode simply holds the loaded word, so cfg_value need not be kept.
    always_comb begin
        case (mode_q)
            2'd1:    nxt = {1'b0, z[WIDTH-1:1]} ^ (z[0] ? POLY_W : '0);
            2'd2:    nxt = z;
            default: nxt = z + WIDTH'(1);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            z      <= '0;
            stb    <= 1'b0;
            cnt    <= '0;
            mode_q <= 2'd0;
        end else if (load) begin
            mode_q <= mode;
            cnt    <= '0;
            stb    <= 1'b1;
            z      <= word0;
        end else if (stop) begin
            stb    <= 1'b0;
        end else if (stb && ack) begin
            cnt <= cnt + CW'(1);
            if (cnt == CW'(COUNT - 1)) stb <= 1'b0;
            else                       z   <= nxt;
        end
    end
endmodule

module stream_harness #(
    parameter int WIDTH      = 16,
    parameter int NUM_INPUTS = 2,
    parameter int COUNT      = 256,
    parameter int SEED       = 16'h0001,
    parameter int POLY       = 16'hB400,
    parameter int TIMEOUT    = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [1:0]                  mode,
    input  logic [WIDTH-1:0]            cfg_value,
    input  logic [3:0]                  throttle,
    output logic [NUM_INPUTS*WIDTH-1:0] output_z,
    output logic [NUM_INPUTS-1:0]       output_z_stb,
    input  logic [NUM_INPUTS-1:0]       output_z_ack,
    input  logic [WIDTH-1:0]            input_a,
    input  logic                        input_a_stb,
    output logic                        input_a_ack,
    output logic                        busy,
    output logic                        done,
    output logic                        timeout,
    output logic [15:0]                 result_count,
    output logic [WIDTH-1:0]            checksum
);
    localparam int IW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                             state;
    logic [3:0]                         phase, thr_q, phase_nxt;
    logic [IW-1:0]                      idle_cnt;
    logic [NUM_INPUTS-1:0][WIDTH-1:0]   z_w;
    logic                               op_xfer, res_xfer, load, fin_cnt, fin_to, stop, wrap;

    assign op_xfer   = |(output_z_stb & output_z_ack);
    assign res_xfer  = input_a_stb && input_a_ack;
    assign load      = start && (state != RUN);
    assign fin_cnt   = res_xfer && (result_count == 16'(COUNT - 1));
    assign fin_to    = !op_xfer && !res_xfer && (idle_cnt == IW'(TIMEOUT - 1));
    assign stop      = (state == RUN) && (fin_cnt || fin_to);
    // Throttle is only re-read at a wrap so a mid-run change never truncates a phase.
    assign wrap      = (phase >= thr_q);
    assign phase_nxt = wrap ? 4'd0 : phase + 4'd1;
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign output_z  = z_w;

    genvar i;
    for (i = 0; i < NUM_INPUTS; i++) begin : g_ch
        stream_harness_chan #(
            .WIDTH(WIDTH), .COUNT(COUNT), .IDX(i), .SEED(SEED), .POLY(POLY)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .load      (load),
            .stop      (stop),
            .mode      (mode),
            .cfg_value (cfg_value),
            .ack       (output_z_ack[i]),
            .z         (z_w[i]),
            .stb       (output_z_stb[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            phase        <= 4'd0;
            thr_q        <= 4'd0;
            input_a_ack  <= 1'b0;
            idle_cnt     <= '0;
            result_count <= 16'd0;
            checksum     <= '0;
            timeout      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state        <= RUN;
                    phase        <= 4'd0;
                    thr_q        <= throttle;
                    input_a_ack  <= 1'b1;
                    idle_cnt     <= '0;
                    result_count <= 16'd0;
                    checksum     <= '0;
                    timeout      <= 1'b0;
                end
                RUN: begin
                    if (res_xfer) begin
                        result_count <= result_count + 16'd1;
                        checksum     <= {checksum[WIDTH-2:0], checksum[WIDTH-1]} ^ input_a;
                    end
                    idle_cnt    <= (op_xfer || res_xfer) ? '0 : idle_cnt + IW'(1);
                    phase       <= phase_nxt;
                    if (wrap) thr_q <= throttle;
                    input_a_ack <= (phase_nxt == 4'd0);
                    if (fin_cnt) begin
                        state       <= DONE;
                        input_a_ack <= 1'b0;
                    end else if (fin_to) begin
                        state       <= DONE;
                        timeout     <= 1'b1;
                        input_a_ack <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stream_harness.sv
// Randomized bench for stream_harness: a queue-based adder responder plus a reference
// model of the generator sequences and checksum fold.

module tb_stream_harness;
    localparam int W = 16;
    localparam int N = 2;
    localparam int CNT = 4;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst, start;
    logic [1:0]     mode;
    logic [W-1:0]   cfg_value;
    logic [3:0]     throttle;
    logic [N*W-1:0] output_z;
    logic [N-1:0]   output_z_stb, output_z_ack;
    logic [W-1:0]   input_a;
    logic           input_a_stb, input_a_ack;
    logic           busy, done, timeout;
    logic [15:0]    result_count;
    logic [W-1:0]   checksum;

    int n_chk = 0;
    int n_pass = 0;

    logic [15:0] opq0[$], opq1[$], rx0[$], rx1[$], res_log[$];

    stream_harness #(.WIDTH(W), .NUM_INPUTS(N), .COUNT(CNT), .SEED(16'h0001),
                     .POLY(16'hB400), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .cfg_value(cfg_value),
        .throttle(throttle), .output_z(output_z), .output_z_stb(output_z_stb),
        .output_z_ack(output_z_ack), .input_a(input_a), .input_a_stb(input_a_stb),
        .input_a_ack(input_a_ack), .busy(busy), .done(done), .timeout(timeout),
        .result_count(result_count), .checksum(checksum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else n_pass++;
    endtask

    // Word k of channel i straight from the generator rules.
    function automatic logic [15:0] gen(input int md, input logic [15:0] cfg, input int i, input int k);
        logic [15:0] w;
        if (md == 2) return cfg;
        if (md == 1) begin
            w = 16'(1 + i);
            if (w == 16'd0) w = 16'd1;
            for (int j = 0; j < k; j++) w = (w >> 1) ^ (w[0] ? 16'hB400 : 16'h0000);
            return w;
        end
        return 16'(k + i);
    endfunction

    // pol: 0 ack all, 1 never ack, 2 ch1 waits 5 cycles per word, 3 random, 4 like 0 but result always strobed
    task automatic run(input int md, input logic [15:0] cfg, input logic [3:0] thr,
                       input int pol, input int abort_at, input string tag);
        int run_cyc, ack_hi, w1;
        bit fin;
        logic [15:0] cs, v;
        opq0.delete(); opq1.delete(); rx0.delete(); rx1.delete(); res_log.delete();
        @(negedge clk);
        mode = 2'(md); cfg_value = cfg; throttle = thr; start = 1'b1;
        output_z_ack = '0; input_a_stb = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy0"}, 32'(busy), 1);
        chk({tag, "_stb0"}, 32'(output_z_stb), 3);
        chk({tag, "_z0"}, output_z, {gen(md, cfg, 1, 0), gen(md, cfg, 0, 0)});
        chk({tag, "_ack0"}, 32'(input_a_ack), 1);
        run_cyc = 0; ack_hi = 0; w1 = 0; fin = 0;
        for (int cyc = 0; cyc < 500 && !fin; cyc++) begin
            if (!busy) fin = 1;
            else begin
                run_cyc++;
                if (input_a_ack) ack_hi++;
                if (abort_at >= 0 && result_count == 16'(abort_at)) begin
                    rst = 1'b1; input_a_stb = 1'b0; output_z_ack = '0;
                    @(negedge clk);
                    chk({tag, "_rbusy"}, 32'(busy), 0);
                    chk({tag, "_rdone"}, 32'(done), 0);
                    chk({tag, "_rstb"}, 32'(output_z_stb), 0);
                    chk({tag, "_rack"}, 32'(input_a_ack), 0);
                    chk({tag, "_rcnt"}, 32'(result_count), 0);
                    chk({tag, "_rcs"}, 32'(checksum), 0);
                    rst = 1'b0;
                    return;
                end
                case (pol)
                    1:       output_z_ack = 2'b00;
                    2:       output_z_ack = {w1 >= 5, 1'b1};
                    3:       output_z_ack = {$urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0};
                    default: output_z_ack = 2'b11;
                endcase
                if (pol == 4) begin
                    input_a_stb = 1'b1; input_a = 16'($urandom);
                end else if (opq0.size() > 0 && opq1.size() > 0) begin
                    input_a_stb = 1'b1; input_a = opq0[0] + opq1[0];
                end else input_a_stb = 1'b0;
                if (input_a_stb && input_a_ack) begin
                    res_log.push_back(input_a);
                    if (pol != 4) begin void'(opq0.pop_front()); void'(opq1.pop_front()); end
                end
                if (output_z_stb[0] && output_z_ack[0]) begin
                    opq0.push_back(output_z[15:0]); rx0.push_back(output_z[15:0]);
                end
                if (output_z_stb[1] && output_z_ack[1]) begin
                    opq1.push_back(output_z[31:16]); rx1.push_back(output_z[31:16]);
                end
                if (output_z_stb[1]) w1 = output_z_ack[1] ? 0 : w1 + 1;
                @(negedge clk);
            end
        end
        output_z_ack = '0; input_a_stb = 1'b0;
        chk({tag, "_finished"}, 32'(fin), 1);
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_stb_end"}, 32'(output_z_stb), 0);
        chk({tag, "_ack_end"}, 32'(input_a_ack), 0);
        if (pol == 1) begin
            chk({tag, "_to"}, 32'(timeout), 1);
            chk({tag, "_to_cyc"}, run_cyc, TO);
            chk({tag, "_to_cnt"}, 32'(result_count), 0);
        end else begin
            chk({tag, "_to"}, 32'(timeout), 0);
            chk({tag, "_cnt"}, 32'(result_count), CNT);
            chk({tag, "_nrx0"}, rx0.size(), CNT);
            chk({tag, "_nrx1"}, rx1.size(), CNT);
            chk({tag, "_nres"}, res_log.size(), CNT);
            chk({tag, "_nack"}, ack_hi, (run_cyc + int'(thr)) / (int'(thr) + 1));
            for (int k = 0; k < CNT && k < rx0.size(); k++) chk({tag, "_w0"}, rx0[k], gen(md, cfg, 0, k));
            for (int k = 0; k < CNT && k < rx1.size(); k++) chk({tag, "_w1"}, rx1[k], gen(md, cfg, 1, k));
            cs = 16'h0000;
            for (int k = 0; k < CNT; k++) begin
                v = (pol == 4) ? (k < res_log.size() ? res_log[k] : 16'h0000)
                               : gen(md, cfg, 0, k) + gen(md, cfg, 1, k);
                cs = {cs[14:0], cs[15]} ^ v;
            end
            chk({tag, "_cs"}, 32'(checksum), 32'(cs));
            if (pol == 4 && thr == 4'd3) chk({tag, "_thr_cyc"}, 32'(run_cyc >= 13 && run_cyc <= 16), 1);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 2'd0; cfg_value = '0; throttle = 4'd0;
        output_z_ack = '0; input_a = '0; input_a_stb = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_stb", 32'(output_z_stb), 0);
        chk("rst_z", output_z, 0);
        chk("rst_ack", 32'(input_a_ack), 0);
        chk("rst_cnt", 32'(result_count), 0);
        chk("rst_cs", 32'(checksum), 0);
        rst = 1'b0;

        run(0, 16'h0000, 4'd0, 0, -1, "inc");
        chk("inc_cs_const", 32'(checksum), 32'h0009);
        run(1, 16'h0000, 4'd0, 0, -1, "lfsr");
        run(2, 16'hA5C3, 4'd1, 0, -1, "const");
        run(0, 16'h0000, 4'd3, 4, -1, "thr3");
        run(0, 16'h0000, 4'd0, 1, -1, "tmo");
        run(0, 16'h0000, 4'd0, 2, -1, "slow1");
        run(0, 16'h0000, 4'd0, 0, 2, "abort");
        @(negedge clk);
        run(0, 16'h0000, 4'd0, 0, -1, "rerun");
        chk("rerun_cs_const", 32'(checksum), 32'h0009);
        for (int r = 0; r < 6; r++)
            run(int'($urandom_range(0, 3)), 16'($urandom), 4'($urandom_range(0, 7)), 3, -1, "rnd");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
